mem_arbiter: RTL

Two-port controller that shares the single-port, 256-word synchronous RAM between the instruction-fetch path and the load/store path of the RV32I core. It arbitrates the requests and converts byte addresses and access sizes into RAM word address, byte mask and lane-aligned write data. It also extracts and sign- or zero-extends load data from the RAM's one-cycle-latency read port. Misaligned or illegal accesses are rejected with an error response and never touch memory.

---
 rtl/mem_arbiter.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, 256-word synchronous RAM between the instruction
// fetch port and the load/store port of the RV32I core. A request is granted
// in IDLE and its address goes straight to the RAM. The arbiter then spends
// one WAIT cycle while the RAM read port delivers the word. The formatted
// result is registered into the owning port's response outputs.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration between the two ports
//   MEM_ARB_RR_EN  undefined -> fixed priority, the data port wins conflicts
module mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_rdata,
  output logic              i_rsp_err,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [1:0]        d_req_size,
  input  logic              d_req_unsigned,
  input  logic [31:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              d_rsp_err,

  output logic              ram_w_en,
  output logic [ADDR_W-3:0] ram_address,
  output logic [3:0]        ram_masking,
  output logic [31:0]       ram_write_data,
  input  logic [31:0]       ram_read_data
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [0:0]  state;
  logic        rst_q;
  logic        can_grant;
  logic        d_wins;
  logic        grant_i;
  logic        grant_d;

  logic        i_err;
  logic        d_err;
  logic [3:0]  store_mask;
  logic [31:0] store_data;

  logic        cap_is_d;
  logic        cap_err;
  logic        cap_we;
  logic        cap_unsigned;
  logic [1:0]  cap_size;
  logic [1:0]  cap_offset;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  // Grants are held off while reset is high and for one cycle after it drops,
  // so the RAM interface stays quiet across the whole reset window.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign can_grant = (state == ST_IDLE) && !rst && !rst_q;

`ifdef MEM_ARB_RR_EN
  logic last_grant_i;

  // Remember which port won the most recent grant so conflicts alternate.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_i <= 1'b1;
    end else if (grant_i || grant_d) begin
      last_grant_i <= grant_i;
    end
  end

  assign d_wins = last_grant_i;
`else
  assign d_wins = 1'b1;
`endif

  // Pick at most one port per IDLE cycle.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (can_grant) begin
      if (d_req_valid && (!i_req_valid || d_wins)) begin
        grant_d = 1'b1;
      end else if (i_req_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  // Classify requests that may not touch memory.
  always_comb begin
    i_err = (i_req_addr[1:0] != 2'b00);
    d_err = 1'b0;
    unique case (d_req_size)
      SZ_BYTE: d_err = 1'b0;
      SZ_HALF: d_err = d_req_addr[0];
      SZ_WORD: d_err = (d_req_addr[1:0] != 2'b00);
      default: d_err = 1'b1;
    endcase
  end

  // Build the byte mask and lane-replicated write data for a store.
  always_comb begin
    store_mask = 4'b0000;
    store_data = 32'h0000_0000;
    unique case (d_req_size)
      SZ_BYTE: begin
        store_mask = 4'b0001 << d_req_addr[1:0];
        store_data = {4{d_req_wdata[7:0]}};
      end
      SZ_HALF: begin
        store_mask = d_req_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{d_req_wdata[15:0]}};
      end
      SZ_WORD: begin
        store_mask = 4'b1111;
        store_data = d_req_wdata;
      end
      default: begin
        store_mask = 4'b0000;
        store_data = 32'h0000_0000;
      end
    endcase
  end

  // Drive the RAM only in the grant cycle; everything else leaves it at zero.
  always_comb begin
    ram_w_en       = 1'b0;
    ram_address    = '0;
    ram_masking    = 4'b0000;
    ram_write_data = 32'h0000_0000;
    if (grant_d) begin
      ram_address = d_req_addr[ADDR_W-1:2];
      if (d_req_we && !d_err) begin
        ram_w_en       = 1'b1;
        ram_masking    = store_mask;
        ram_write_data = store_data;
      end
    end else if (grant_i) begin
      ram_address = i_req_addr[ADDR_W-1:2];
    end
  end

  // Two-state sequencing: IDLE grants, WAIT collects the RAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (grant_i || grant_d) state <= ST_WAIT;
        ST_WAIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the granted request so WAIT knows how to format the answer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_is_d     <= 1'b0;
      cap_err      <= 1'b0;
      cap_we       <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= 2'b00;
      cap_offset   <= 2'b00;
    end else if (grant_d) begin
      cap_is_d     <= 1'b1;
      cap_err      <= d_err;
      cap_we       <= d_req_we;
      cap_unsigned <= d_req_unsigned;
      cap_size     <= d_req_size;
      cap_offset   <= d_req_addr[1:0];
    end else if (grant_i) begin
      cap_is_d     <= 1'b0;
      cap_err      <= i_err;
      cap_we       <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= SZ_WORD;
      cap_offset   <= 2'b00;
    end
  end

  // Select the addressed lane of the read word and extend it to 32 bits.
  always_comb begin
    load_byte  = 8'h00;
    load_half  = 16'h0000;
    load_value = ram_read_data;
    unique case (cap_offset)
      2'd0: load_byte = ram_read_data[7:0];
      2'd1: load_byte = ram_read_data[15:8];
      2'd2: load_byte = ram_read_data[23:16];
      default: load_byte = ram_read_data[31:24];
    endcase
    load_half = cap_offset[1] ? ram_read_data[31:16] : ram_read_data[15:0];
    unique case (cap_size)
      SZ_BYTE: load_value = cap_unsigned ? {24'h000000, load_byte}
                                         : {{24{load_byte[7]}}, load_byte};
      SZ_HALF: load_value = cap_unsigned ? {16'h0000, load_half}
                                         : {{16{load_half[15]}}, load_half};
      default: load_value = ram_read_data;
    endcase
  end

  // Register the response for the port that owns the access in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rsp_valid <= 1'b0;
      i_rsp_rdata <= 32'h0000_0000;
      i_rsp_err   <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= 32'h0000_0000;
      d_rsp_err   <= 1'b0;
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      if (state == ST_WAIT) begin
        if (cap_is_d) begin
          d_rsp_valid <= 1'b1;
          d_rsp_err   <= cap_err;
          d_rsp_rdata <= (cap_err || cap_we) ? 32'h0000_0000 : load_value;
        end else begin
          i_rsp_valid <= 1'b1;
          i_rsp_err   <= cap_err;
          i_rsp_rdata <= cap_err ? 32'h0000_0000 : ram_read_data;
        end
      end
    end
  end

endmodule
